// File: rtl/debug_dump_if.sv
// Handshake and data signals between the debug dump engine, the CPU and the record sink.
interface debug_dump_if;
   logic        start;
   logic        halt_req;
   logic        halt_ack;
   logic [31:0] pc_addr;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_index;
   logic [31:0] out_data;
   logic        busy;
   logic        done;

   modport master (
      input  start, halt_ack, pc_addr, rd_data, out_ready,
      output halt_req, rd_addr, out_valid, out_index, out_data, busy, done
   );

   modport slave (
      output start, halt_ack, pc_addr, rd_data, out_ready,
      input  halt_req, rd_addr, out_valid, out_index, out_data, busy, done
   );
endinterface

// File: rtl/debug_dump.sv
// Freezes the CPU and streams each register (and optionally a PC snapshot) out as
// indexed records over a valid/ready handshake, one record per LOAD/SEND pair.
module debug_dump #(
   parameter int NUM_REGS   = 32,
   parameter bit INCLUDE_PC = 1'b1
) (
   input  logic          clock,
   input  logic          reset,
   debug_dump_if.master  dbg
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_LOAD   = 3'd2;
   localparam logic [2:0] S_SEND   = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;

   localparam logic [5:0] PC_IDX   = 6'd32;
   localparam logic [5:0] LAST_REG = 6'(NUM_REGS - 1);
   localparam logic [5:0] LAST_IDX = INCLUDE_PC ? PC_IDX : LAST_REG;

   logic [2:0]  state_q, state_d;
   logic [5:0]  idx_q, idx_d;
   logic [31:0] pc_q, pc_d;
   logic [5:0]  oidx_q, oidx_d;
   logic [31:0] odata_q, odata_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pc_d    = pc_q;
      oidx_d  = oidx_q;
      odata_d = odata_q;
      case (state_q)
         S_IDLE: if (dbg.start) state_d = S_WAIT;
         S_WAIT: begin
            if (dbg.halt_ack) begin
               state_d = S_LOAD;
               pc_d    = dbg.pc_addr;
               idx_d   = '0;
            end
         end
         S_LOAD: begin
            oidx_d  = idx_q;
            odata_d = (idx_q == PC_IDX) ? pc_q : dbg.rd_data;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (dbg.out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_LOAD;
                  // Short banks skip straight from the last register to the PC record.
                  idx_d   = (INCLUDE_PC && idx_q == LAST_REG) ? PC_IDX : idx_q + 6'd1;
               end
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         pc_q    <= '0;
         oidx_q  <= '0;
         odata_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pc_q    <= pc_d;
         oidx_q  <= oidx_d;
         odata_q <= odata_d;
      end
   end

   assign dbg.busy      = (state_q != S_IDLE);
   assign dbg.halt_req  = (state_q != S_IDLE);
   assign dbg.done      = (state_q == S_FINISH);
   assign dbg.out_valid = (state_q == S_SEND);
   assign dbg.rd_addr   = (state_q == S_LOAD) ? idx_q[4:0] : 5'd0;
   assign dbg.out_index = oidx_q;
   assign dbg.out_data  = odata_q;
endmodule

// File: tb/tb_debug_dump.sv
// Directed bench for debug_dump: a record-ordinal model predicts every record, done and
// the idle/hold rules; three instances cover the default and the 4-register variants.
module tb_debug_dump;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        halt_ack = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] pc_addr = '0;
   logic [31:0] regs [32];
   logic [1:0]  sel = 2'd0;

   always #5 clock = ~clock;

   debug_dump_if bus0 ();
   debug_dump_if bus1 ();
   debug_dump_if bus2 ();

   debug_dump u0 (.clock(clock), .reset(reset), .dbg(bus0));
   debug_dump #(.NUM_REGS(4), .INCLUDE_PC(1'b1)) u1 (.clock(clock), .reset(reset), .dbg(bus1));
   debug_dump #(.NUM_REGS(4), .INCLUDE_PC(1'b0)) u2 (.clock(clock), .reset(reset), .dbg(bus2));

   assign bus0.start = start && (sel == 2'd0);
   assign bus1.start = start && (sel == 2'd1);
   assign bus2.start = start && (sel == 2'd2);
   assign bus0.halt_ack = halt_ack;
   assign bus1.halt_ack = halt_ack;
   assign bus2.halt_ack = halt_ack;
   assign bus0.pc_addr = pc_addr;
   assign bus1.pc_addr = pc_addr;
   assign bus2.pc_addr = pc_addr;
   assign bus0.out_ready = out_ready;
   assign bus1.out_ready = out_ready;
   assign bus2.out_ready = out_ready;
   assign bus0.rd_data = regs[bus0.rd_addr];
   assign bus1.rd_data = regs[bus1.rd_addr];
   assign bus2.rd_data = regs[bus2.rd_addr];

   // Observed outputs of the instance under test, selected by sel.
   logic [46:0] obs [3];
   logic        m_valid, m_busy, m_done, m_halt;
   logic [4:0]  m_rd;
   logic [5:0]  m_idx;
   logic [31:0] m_data;
   assign obs[0] = {bus0.out_valid, bus0.busy, bus0.done, bus0.halt_req, bus0.rd_addr, bus0.out_index, bus0.out_data};
   assign obs[1] = {bus1.out_valid, bus1.busy, bus1.done, bus1.halt_req, bus1.rd_addr, bus1.out_index, bus1.out_data};
   assign obs[2] = {bus2.out_valid, bus2.busy, bus2.done, bus2.halt_req, bus2.rd_addr, bus2.out_index, bus2.out_data};
   assign {m_valid, m_busy, m_done, m_halt, m_rd, m_idx, m_data} = obs[sel];

   // Model configuration for the dump in progress.
   int          mdl_n = 32;
   bit          mdl_pc_en = 1'b1;
   logic [31:0] mdl_pc = 32'h40;

   int          checks = 0;
   int          errors = 0;
   int          k = 0;
   int          bcnt = 0;
   int          dcnt = 0;
   bit          last_hs = 1'b0;
   bit          hold_v = 1'b0;
   bit          prev_busy = 1'b0;
   logic [5:0]  hold_idx;
   logic [31:0] hold_data;
   logic [5:0]  rx_idx [64];
   logic [31:0] rx_data [64];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic int total_recs();
      return mdl_n + (mdl_pc_en ? 1 : 0);
   endfunction

   function automatic logic [5:0] exp_idx(input int kk);
      return (kk < mdl_n) ? 6'(kk) : 6'd32;
   endfunction

   // Compare process: record ordinal k maps to the expected index/value.
   always @(negedge clock) begin
      logic [5:0] e;
      if (reset) begin
         last_hs   = 1'b0;
         hold_v    = 1'b0;
         prev_busy = 1'b0;
      end else begin
         if (m_busy && !prev_busy) begin
            k    = 0;
            bcnt = 0;
         end
         chk("done", m_done, last_hs);
         chk("halt_req", m_halt, m_busy);
         if (!m_busy) chk("valid_idle", m_valid, 1'b0);
         if (!m_busy || m_valid || m_done) chk("rd_addr_idle", m_rd, 5'd0);
         if (hold_v) begin
            chk("hold_valid", m_valid, 1'b1);
            chk("hold_index", m_idx, hold_idx);
            chk("hold_data", m_data, hold_data);
         end
         last_hs = 1'b0;
         hold_v  = 1'b0;
         if (m_valid && out_ready) begin
            if (k >= total_recs()) begin
               checks++;
               errors++;
               $display("FAIL extra_record actual=%0d expected_max=%0d", k + 1, total_recs());
            end else begin
               e = exp_idx(k);
               chk("rec_index", m_idx, e);
               chk("rec_data", m_data, (e == 6'd32) ? mdl_pc : regs[e[4:0]]);
               rx_idx[k]  = m_idx;
               rx_data[k] = m_data;
               k++;
               last_hs = (k == total_recs());
            end
         end else if (m_valid) begin
            hold_v    = 1'b1;
            hold_idx  = m_idx;
            hold_data = m_data;
         end
         if (m_done) begin
            dcnt++;
            chk("rec_count_at_done", k, total_recs());
         end
         if (m_busy && !m_done) bcnt++;
         prev_busy = m_busy;
      end
   end

   task automatic rst_check(input string nm);
      chk({nm, "_valid"}, m_valid, 1'b0);
      chk({nm, "_busy"}, m_busy, 1'b0);
      chk({nm, "_done"}, m_done, 1'b0);
      chk({nm, "_halt"}, m_halt, 1'b0);
      chk({nm, "_rd_addr"}, m_rd, 5'd0);
      chk({nm, "_index"}, m_idx, 6'd0);
      chk({nm, "_data"}, m_data, 32'd0);
   endtask

   task automatic pulse_start();
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
   endtask

   task automatic run_dump(input int lim, input bit rnd);
      int n = 0;
      do begin
         @(posedge clock); #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         n++;
      end while (!m_done && n < lim);
      chk("dump_timeout", m_done, 1'b1);
      out_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
   endtask

   initial begin
      int d0;
      int n;
      for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);

      // Reset state
      #3 rst_check("reset");
      @(posedge clock); #2 reset = 1'b0;

      // Full default dump, ack tied high, sink always ready
      halt_ack = 1'b1; out_ready = 1'b1; pc_addr = 32'h40;
      mdl_n = 32; mdl_pc_en = 1'b1; mdl_pc = 32'h40;
      d0 = dcnt;
      pulse_start();
      run_dump(300, 1'b0);
      chk("t1_records", k, 33);
      chk("t1_busy_cycles", bcnt, 67);
      chk("t1_done_pulses", dcnt - d0, 1);
      chk("t1_idx0", rx_idx[0], 6'd0);
      chk("t1_data0", rx_data[0], 32'd0);
      chk("t1_data5", rx_data[5], 32'd15);
      chk("t1_data31", rx_data[31], 32'd93);
      chk("t1_idx32", rx_idx[32], 6'd32);
      chk("t1_pc", rx_data[32], 32'h40);

      // Random backpressure with a different register pattern
      for (int i = 0; i < 32; i++) regs[i] = 32'hC0DE0000 + 32'(i * i * 5);
      d0 = dcnt;
      pulse_start();
      run_dump(1000, 1'b1);
      chk("t2_records", k, 33);
      chk("t2_done_pulses", dcnt - d0, 1);
      chk("t2_data7", rx_data[7], 32'hC0DE00F5);

      // Delayed ack; PC moves before and after the ack cycle
      halt_ack = 1'b0; pc_addr = 32'h100; mdl_pc = 32'h1234;
      pulse_start();
      repeat (4) begin
         @(posedge clock); #1 pc_addr = pc_addr + 32'd4;
      end
      chk("t3_waiting_valid", m_valid, 1'b0);
      chk("t3_waiting_halt", m_halt, 1'b1);
      @(posedge clock); #1 pc_addr = 32'h1234; halt_ack = 1'b1;
      @(posedge clock); #1 pc_addr = 32'hDEAD; halt_ack = 1'b0;
      run_dump(300, 1'b0);
      chk("t3_records", k, 33);
      chk("t3_pc", rx_data[32], 32'h1234);
      halt_ack = 1'b1;

      // Four-register variants
      for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
      pc_addr = 32'h77; mdl_pc = 32'h77;
      sel = 2'd1; mdl_n = 4; mdl_pc_en = 1'b1;
      pulse_start();
      run_dump(100, 1'b0);
      chk("t4a_records", k, 5);
      chk("t4a_idx3", rx_idx[3], 6'd3);
      chk("t4a_idx4", rx_idx[4], 6'd32);
      chk("t4a_pc", rx_data[4], 32'h77);
      sel = 2'd2; mdl_pc_en = 1'b0;
      pulse_start();
      run_dump(100, 1'b0);
      chk("t4b_records", k, 4);
      chk("t4b_data3", rx_data[3], 32'd9);

      // Reset after the 10th handshake, then restart on the first edge after release
      sel = 2'd0; mdl_n = 32; mdl_pc_en = 1'b1; pc_addr = 32'h40; mdl_pc = 32'h40;
      pulse_start();
      n = 0;
      while (k < 10 && n < 200) begin
         @(posedge clock); #1 n++;
      end
      chk("t5_reach_10", k, 10);
      #1 reset = 1'b1;
      d0 = dcnt;
      #1 rst_check("t5_abort");
      @(posedge clock);
      @(posedge clock); #2 reset = 1'b0; start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      chk("t5_start_after_reset", m_busy, 1'b1);
      run_dump(300, 1'b0);
      chk("t5_records", k, 33);
      chk("t5_done_pulses", dcnt - d0, 1);
      chk("t5_first_idx", rx_idx[0], 6'd0);

      // Start pulsed during SEND is ignored
      d0 = dcnt;
      pulse_start();
      n = 0;
      while (!m_valid && n < 20) begin
         @(posedge clock); #1 n++;
      end
      chk("t6_reach_send", m_valid, 1'b1);
      start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
      run_dump(300, 1'b0);
      repeat (10) @(posedge clock);
      #1;
      chk("t6_idle_after", m_busy, 1'b0);
      chk("t6_records", k, 33);
      chk("t6_done_pulses", dcnt - d0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
